// File: rtl/count_seq_ctrl_if.sv
// Control/status bundle for count_seq_ctrl.
//   master: drives ss, ud, sel_freq, load, loop, start_vl, stop_vl; observes status.
//   slave : the sequencer; drives count, tick, done, state, LED.
interface count_seq_ctrl_if;
  logic       ss;
  logic       ud;
  logic       sel_freq;
  logic       load;
  logic       loop;
  logic [3:0] start_vl;
  logic [3:0] stop_vl;
  logic [3:0] count;
  logic       tick;
  logic       done;
  logic [1:0] state;
  logic [7:0] LED;

  modport master (
    output ss, ud, sel_freq, load, loop, start_vl, stop_vl,
    input  count, tick, done, state, LED
  );

  modport slave (
    input  ss, ud, sel_freq, load, loop, start_vl, stop_vl,
    output count, tick, done, state, LED
  );
endinterface

// File: rtl/count_seq_ctrl.sv
// Run/pause/load sequencer for the 4-bit start/stop LED counter. Single clock domain; a
// prescaler produces a one-cycle step enable instead of a gated clock.
//   clk_in  : system clock
//   rst     : synchronous active-high reset
//   bus_io  : slave side of count_seq_ctrl_if
//             inputs  ss, ud, sel_freq, load, loop, start_vl, stop_vl
//             outputs count, tick, done, state (IDLE=00 RUN=01 PAUSE=10 DONE=11),
//                     LED = {ud, done, pause, run, count}
module count_seq_ctrl #(
  parameter int unsigned DIV        = 100000000,
  parameter int unsigned FAST_SHIFT = 2
) (
  input logic            clk_in,
  input logic            rst,
  count_seq_ctrl_if.slave bus_io
);

  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] TermSlow = PW'(DIV - 1);
  localparam logic [PW-1:0] TermFast = PW'((DIV >> FAST_SHIFT) - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StDone  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          done_q;
  logic [7:0]    led_q;

  logic [PW-1:0] term;
  assign term = bus_io.sel_freq ? TermFast : TermSlow;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    case (state_q)
      StIdle: begin
        // Display follows the start switches while idle.
        count_d = bus_io.start_vl;
        presc_d = '0;
        if (!bus_io.ss) state_d = StRun;
      end
      StRun: begin
        if (bus_io.load) begin
          count_d = bus_io.start_vl;
          presc_d = '0;
        end else if (bus_io.ss) begin
          // Prescaler held so the partial period survives the pause.
          state_d = StPause;
        end else if (presc_q >= term) begin
          // >= so a switch to the fast rate mid-period still ticks promptly.
          presc_d = '0;
          tick_d  = 1'b1;
          if (count_q == bus_io.stop_vl) begin
            if (bus_io.loop) count_d = bus_io.start_vl;
            else             state_d = StDone;
          end else if (bus_io.ud) begin
            count_d = count_q + 4'd1;
          end else begin
            count_d = count_q - 4'd1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      StPause: begin
        if (bus_io.load) begin
          count_d = bus_io.start_vl;
          presc_d = '0;
        end else if (!bus_io.ss) begin
          state_d = StRun;
        end
      end
      StDone: begin
        presc_d = '0;
        if (bus_io.load) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= 4'd0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      led_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      done_q  <= (state_d == StDone);
      led_q   <= {bus_io.ud, state_d == StDone, state_d == StPause, state_d == StRun, count_d};
    end
  end

  assign bus_io.count = count_q;
  assign bus_io.tick  = tick_q;
  assign bus_io.done  = done_q;
  assign bus_io.state = state_q;
  assign bus_io.LED   = led_q;

endmodule

// File: doc/count_seq_ctrl.md
Name: count_seq_ctrl

Overview:
- Run/pause/load sequencer for the 4-bit start/stop LED counter.
- Replaces clock gating with a clock-enable scheme. Everything runs on clk_in. A one-cycle tick enable is derived from a prescaler.
- Sequences the count from start_vl to stop_vl, then either wraps or halts, and reports state on LED.
- count drives the existing 7-segment decoder directly.

Parameters:
DIV, 100000000, clk_in cycles per tick at slow rate (sel_freq=0); DIV must be a multiple of 4 and >= 8
FAST_SHIFT, 2, fast rate (sel_freq=1) tick period = DIV >> FAST_SHIFT

Ports:
clk_in  input  1  system clock, single clock domain
rst  input  1  synchronous, active-high reset
ss  input  1  level; 1 = stop/pause, 0 = run
ud  input  1  direction; 1 = up, 0 = down, sampled on each tick
sel_freq  input  1  0 = slow period DIV, 1 = fast period DIV>>FAST_SHIFT
load  input  1  single-cycle pulse; reload start_vl / leave DONE
loop  input  1  at stop value: 1 = wrap to start_vl, 0 = halt in DONE
start_vl  input  4  first count value
stop_vl  input  4  terminal count value
count  output  4  current count value, to the 7-seg decoder
tick  output  1  one-cycle pulse when count steps or evaluates terminal
done  output  1  high while in DONE
state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11
LED  output  8  {ud, done, pause, run, count[3:0]}

Behaviour:
- Reset, synchronous, checked at the rising clk_in edge:
  - state=IDLE, count=0, prescaler=0, tick=0, done=0, LED=8'h00.
  - rst has priority over all inputs and can be asserted in any state.
- Prescaler width is clog2(DIV). Terminal value T = DIV-1, or (DIV>>FAST_SHIFT)-1 when sel_freq=1.
- Prescaler behaviour per state:
  - RUN: increments each cycle. When prescaler >= T, tick=1 for that cycle and prescaler goes to 0. The >= compare makes a sel_freq change mid-period ticks at most one cycle later.
  - PAUSE: prescaler holds its value, so the partial period is kept on resume.
  - IDLE/DONE: prescaler cleared to 0.
  - tick is never asserted outside RUN.
- Priority per cycle: rst > load > ss > tick.
- IDLE:
  - count <= start_vl every cycle, so the display tracks the switches.
  - ss=0 -> RUN.
- RUN:
  - load=1 -> count <= start_vl, prescaler <= 0, stay RUN, no step that cycle.
  - else ss=1 -> PAUSE. No step even if tick coincides; the prescaler value at that edge is held.
  - else on tick:
    - If count==stop_vl: loop=1 -> count <= start_vl; loop=0 -> DONE with count held.
    - Otherwise count <= count+1 (ud=1) or count-1 (ud=0), modulo 16.
  - Consequences of these rules:
    - The stop value is displayed for one full tick period before wrap/halt.
    - Wrong-direction settings (e.g. ud=1, start>stop) traverse through 15->0 or 0->15 until stop_vl is reached.
    - start_vl==stop_vl halts/wraps on the first tick.
- PAUSE:
  - load=1 -> count <= start_vl, prescaler <= 0, stay PAUSE.
  - ss=0 -> RUN.
- DONE:
  - done=1, count held.
  - load=1 -> IDLE.
  - ss has no effect.
- Outputs are all registered: count, state, done, tick.
- LED is registered and derived as {ud, state==DONE, state==PAUSE, state==RUN, count}. It reflects the current register state with no added latency beyond the register.
- Changing start_vl/stop_vl during RUN takes effect at the next terminal compare or load; no other side effect.

Test Plan (DIV=8, FAST_SHIFT=2 in bench):
1. rst=1 for 2 cycles, then ss=1 -> count=0, LED=00. Release rst -> IDLE, count=start_vl=3 next cycle.
2. start=3, stop=6, ud=1, loop=0, ss=0, sel_freq=0:
   - ticks every 8 cycles; count 3,4,5,6.
   - on the tick after count=6, state=DONE, done=1, LED=8'hC6 (ud=1, done=1, count=6).
   - load -> IDLE.
3. start=2, stop=14, ud=0, loop=1:
   - count 2,1,0,15,14 on successive ticks, then 2 on the next tick.
   - sel_freq=1 -> tick period 2 cycles.
4. Pause mid-period: in RUN, assert ss=1 five cycles after a tick -> PAUSE, count frozen. Release after 20 cycles -> next tick 3 cycles later (prescaler retained).
5. Collisions:
   - load and tick in the same RUN cycle -> count=start_vl, no step; next tick 8 cycles later.
   - ss=1 and tick in the same cycle -> PAUSE, count unchanged.
6. Reset mid-operation: rst=1 in RUN with count=9 -> next cycle IDLE, count=0, tick=0, done=0.
